// File: rtl/sm2201_bridge_pkg.sv
// sm2201_bridge_pkg: shared types, status bit positions and window decode for the ISA-CAMAC bridge
package sm2201_bridge_pkg;
    typedef enum logic [1:0] {IDLE, CB_STROBE, CB_WAIT, HOLD} state_t;
    localparam int ST_TMO = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_LAM = 2;
    localparam logic [7:0] TMO_FILL = 8'hFF;
    typedef struct packed {
        logic hit;
        logic status;
        logic hi;
        logic [7:0] ch;
    } dec_t;
    function automatic dec_t decode(input logic [9:0] addr, input logic [9:0] base, input int unsigned n);
        dec_t d;
        logic [9:0] off;
        off = addr - base;
        d.hit = (addr >= base) && (off <= 10'(2 * n));
        d.status = off == 10'(2 * n);
        d.hi = off[0];
        d.ch = 8'(off >> 1);
        return d;
    endfunction
endpackage

// File: rtl/isa_camac_bus_bridge_strobe_detect.sv
// isa_strobe_detect: registers ISA ior/iow and flags their falling (start) and rising (release) edges
module isa_strobe_detect (
    input  logic clk,
    input  logic rst,
    input  logic ior,
    input  logic iow,
    output logic read_start,
    output logic write_start,
    output logic read_released,
    output logic write_released
);
    logic ior_q, iow_q;
    // previous strobe levels; idle bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            ior_q <= 1'b1;
            iow_q <= 1'b1;
        end else begin
            ior_q <= ior;
            iow_q <= iow;
        end
    end
    assign read_start = ior_q & ~ior;
    assign write_start = iow_q & ~iow;
    assign read_released = ~ior_q & ior;
    assign write_released = ~iow_q & iow;
endmodule

// File: rtl/isa_camac_bus_bridge.sv
// isa_camac_bus_bridge: ISA I/O window to CAMAC read/write bridge; ISA_CAMAC_LAM_IRQ_EN enables the LAM interrupt
module isa_camac_bus_bridge import sm2201_bridge_pkg::*; #(
    parameter logic [9:0] BASE_ADDR = 10'h100,
    parameter int NUM_CHANNELS = 4,
    parameter logic [11:0] CB_ADDR_BASE = 12'h000,
    parameter int STROBE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic        isa_aen,
    input  logic [9:0]  isa_addr,
    input  logic [7:0]  isa_data_in,
    output logic [7:0]  isa_data_out,
    output logic        isa_data_oe,
    output logic        isa_chrdy,
    output logic        isa_irq,
    input  logic        cb_prr,
    input  logic        cb_zk4,
    input  logic [15:0] cb_data_in,
    output logic [15:0] cb_data_out,
    output logic        cb_data_oe,
    output logic [11:0] cb_addr,
    output logic        cb_b_b1,
    output logic        cb_cx1
);
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + STROBE_CYCLES + 1);
    state_t state, nxt;
    dec_t dec;
    logic rd_start, wr_start, rd_rel, wr_rel;
    logic go_rd, go_wr, cb_go, rel, out, cb_act, ack, tmo_hit, fin, lam;
    logic is_rd, st, gone, tmo;
    logic [CW-1:0] ch, dch;
    logic [TW-1:0] cnt;
    logic [7:0] rd_data, status_val;
    logic [11:0] addr_q;
    logic [15:0] wdata;
    logic [7:0] shadow [NUM_CHANNELS];
    logic [15:0] latch [NUM_CHANNELS];

    isa_strobe_detect u_det (
        .clk(isa_clk),
        .rst(isa_reset),
        .ior(isa_ior),
        .iow(isa_iow),
        .read_start(rd_start),
        .write_start(wr_start),
        .read_released(rd_rel),
        .write_released(wr_rel)
    );

`ifdef ISA_CAMAC_LAM_IRQ_EN
    logic [1:0] zk_s;
    // two-flop synchroniser for the asynchronous active-low LAM line
    always_ff @(posedge isa_clk) begin
        zk_s <= isa_reset ? 2'b11 : {zk_s[0], cb_zk4};
    end
    assign lam = ~zk_s[1];
`else
    logic unused_zk4;
    assign unused_zk4 = cb_zk4;
    assign lam = 1'b0;
`endif

    assign dec = decode(isa_addr, BASE_ADDR, NUM_CHANNELS);
    assign dch = CW'(dec.ch);

    // start qualification, cycle completion and next-state selection
    always_comb begin
        go_rd = rd_start & ~isa_aen & dec.hit;
        go_wr = wr_start & ~rd_start & ~isa_aen & dec.hit;
        cb_go = ~dec.status & (go_rd ? ~dec.hi : dec.hi);
        rel = is_rd ? rd_rel : wr_rel;
        out = gone | rel;
        cb_act = state == CB_STROBE || state == CB_WAIT;
        ack = state == CB_WAIT && !cb_prr;
        tmo_hit = cb_act && !ack && cnt == TW'(TIMEOUT_CYCLES - 1);
        fin = ack | tmo_hit;
        status_val = '0;
        status_val[ST_TMO] = tmo;
        status_val[ST_BUSY] = state != IDLE;
        status_val[ST_LAM] = lam;
        nxt = state;
        if (state == IDLE)
            nxt = (go_rd | go_wr) ? (cb_go ? CB_STROBE : HOLD) : IDLE;
        else if (fin)
            nxt = out ? IDLE : HOLD;
        else if (state == CB_STROBE && cnt == TW'(STROBE_CYCLES - 1))
            nxt = CB_WAIT;
        else if (state == HOLD && out)
            nxt = IDLE;
    end

    assign isa_chrdy = ~cb_act;
    assign isa_data_oe = state == HOLD && is_rd && !isa_aen;
    assign isa_data_out = isa_data_oe ? rd_data : 8'h00;
    assign isa_irq = lam;
    assign cb_b_b1 = state == CB_STROBE && is_rd;
    assign cb_cx1 = state == CB_STROBE && !is_rd;
    assign cb_data_oe = cb_act && !is_rd;
    assign cb_data_out = wdata;
    assign cb_addr = addr_q;

    // cycle context, shadow/latch storage, read data and sticky timeout
    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            state <= IDLE;
            is_rd <= 1'b0;
            st <= 1'b0;
            gone <= 1'b0;
            tmo <= 1'b0;
            ch <= '0;
            cnt <= '0;
            rd_data <= 8'h00;
            addr_q <= CB_ADDR_BASE;
            wdata <= 16'h0000;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= 8'h00;
                latch[i] <= 16'h0000;
            end
        end else begin
            state <= nxt;
            cnt <= state == IDLE ? '0 : cnt + 1'b1;
            gone <= state == IDLE ? 1'b0 : gone | rel;
            if (state == IDLE && (go_rd | go_wr)) begin
                is_rd <= go_rd;
                st <= dec.status;
                ch <= dch;
                rd_data <= dec.status ? status_val : latch[dch][15:8];
                if (cb_go)
                    addr_q <= CB_ADDR_BASE + 12'(dch);
                if (go_wr && !dec.hi && !dec.status)
                    shadow[dch] <= isa_data_in;
                if (go_wr && cb_go)
                    wdata <= {isa_data_in, shadow[dch]};
            end
            if (fin && is_rd && !out)
                rd_data <= ack ? cb_data_in[7:0] : TMO_FILL;
            if (ack && is_rd && !out)
                latch[ch] <= cb_data_in;
            if (tmo_hit)
                tmo <= 1'b1;
            else if (state == HOLD && out && is_rd && st)
                tmo <= 1'b0;
        end
    end
endmodule

// File: tb/tb_isa_camac_bus_bridge.sv
// tb_isa_camac_bus_bridge: directed stimulus with queued expectations checked by bus monitors
module tb_isa_camac_bus_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ior = 1'b1, iow = 1'b1, aen = 1'b0;
    logic [9:0] addr = 10'h000;
    logic [7:0] din = 8'h00;
    logic prr = 1'b1, zk4 = 1'b1;
    logic [15:0] cbin = 16'hA55A;
    logic [7:0] isa_data_out;
    logic isa_data_oe, isa_chrdy, isa_irq;
    logic [15:0] cb_data_out;
    logic cb_data_oe, cb_b_b1, cb_cx1;
    logic [11:0] cb_addr;
    logic [41:0] outs;

`ifdef ISA_CAMAC_LAM_IRQ_EN
    localparam logic LAM = 1'b1;
`else
    localparam logic LAM = 1'b0;
`endif
    localparam logic [41:0] RST_V = {8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 12'h000, 1'b0, 1'b0};
    localparam logic [41:0] IDLE0_V = {8'h00, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 12'h001, 1'b0, 1'b0};
    localparam logic [41:0] IDLEL_V = {8'h00, 1'b0, 1'b1, LAM, 16'h1234, 1'b0, 12'h001, 1'b0, 1'b0};

    typedef struct {logic seen; logic [7:0] d; int wt;} iev_t;
    typedef struct {logic wr; logic [11:0] a; logic [15:0] d; int len; int oe;} cev_t;
    typedef struct {string n; logic [41:0] v;} snap_t;
    iev_t iq[$];
    cev_t cq[$];
    snap_t sq[$];

    int tests = 0, fails = 0, stray = 0, icnt = 0, ccnt = 0;
    int resp_delay = 4;
    logic resp_en = 1'b1;
    logic done = 1'b0, fin = 1'b0;

    always #5 clk = ~clk;

    isa_camac_bus_bridge dut (
        .isa_clk(clk),
        .isa_reset(rst),
        .isa_ior(ior),
        .isa_iow(iow),
        .isa_aen(aen),
        .isa_addr(addr),
        .isa_data_in(din),
        .isa_data_out(isa_data_out),
        .isa_data_oe(isa_data_oe),
        .isa_chrdy(isa_chrdy),
        .isa_irq(isa_irq),
        .cb_prr(prr),
        .cb_zk4(zk4),
        .cb_data_in(cbin),
        .cb_data_out(cb_data_out),
        .cb_data_oe(cb_data_oe),
        .cb_addr(cb_addr),
        .cb_b_b1(cb_b_b1),
        .cb_cx1(cb_cx1)
    );

    assign outs = {isa_data_out, isa_data_oe, isa_chrdy, isa_irq, cb_data_out, cb_data_oe, cb_addr, cb_b_b1, cb_cx1};

    task automatic exp_isa(input logic seen, input logic [7:0] d, input int wt);
        iev_t e;
        e.seen = seen;
        e.d = d;
        e.wt = wt;
        iq.push_back(e);
    endtask

    task automatic exp_cb(input logic wr, input logic [11:0] a, input logic [15:0] d, input int len, input int oe);
        cev_t e;
        e.wr = wr;
        e.a = a;
        e.d = d;
        e.len = len;
        e.oe = oe;
        cq.push_back(e);
    endtask

    task automatic snap(input string n, input logic [41:0] v);
        snap_t s;
        s.n = n;
        s.v = v;
        sq.push_back(s);
    endtask

    task automatic isa_cyc(input logic rd, input logic wr, input logic [9:0] a, input logic [7:0] d, input logic ae, input int early);
        @(posedge clk);
        #1;
        addr = a;
        din = d;
        aen = ae;
        ior = ~rd;
        iow = ~wr;
        if (early > 0) begin
            repeat (early) @(posedge clk);
        end else begin
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < 100 && !isa_chrdy; i++) begin
                @(posedge clk);
                #1;
            end
            if (!isa_chrdy) begin
                $display("FAIL chrdy_wait act chrdy=%b req chrdy=1 within 100 cycles", isa_chrdy);
                $fatal(1, "chrdy never returned");
            end
            repeat (2) @(posedge clk);
        end
        #1;
        ior = 1'b1;
        iow = 1'b1;
        aen = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    logic rbusy = 1'b0, armed = 1'b0;
    int rc = 0;
    // CAMAC slave model: acknowledges resp_delay cycles after a strobe begins
    always @(negedge clk) begin
        if (!prr)
            prr = 1'b1;
        else if (rbusy) begin
            rc++;
            if (rc >= resp_delay) begin
                prr = 1'b0;
                rbusy = 1'b0;
            end
        end else if ((cb_b_b1 | cb_cx1) && resp_en && !armed) begin
            rbusy = 1'b1;
            rc = 0;
            armed = 1'b1;
        end
        if (!cb_b_b1 && !cb_cx1 && !rbusy)
            armed = 1'b0;
    end

    logic i_act = 1'b0, i_seen = 1'b0, i_bad = 1'b0;
    logic [7:0] i_d = 8'h00;
    int i_wt = 0;
    logic c_act = 1'b0, c_wr = 1'b0;
    logic [11:0] c_a = 12'h000;
    logic [15:0] c_d = 16'h0000;
    int c_len = 0, c_oe = 0;
    // monitor: gathers ISA and CAMAC transactions and compares them with the queues
    always @(negedge clk) begin
        snap_t s;
        iev_t e;
        cev_t c;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            tests++;
            if (outs !== s.v) begin
                fails++;
                $display("FAIL snap_%s act=%h req=%h", s.n, outs, s.v);
            end
        end
        if (!ior || !iow) begin
            if (!i_act) begin
                i_act = 1'b1;
                i_seen = 1'b0;
                i_d = 8'h00;
                i_wt = 0;
                i_bad = 1'b0;
            end
            if (!isa_chrdy)
                i_wt++;
            if (isa_data_oe) begin
                i_seen = 1'b1;
                i_d = isa_data_out;
            end
            if ((!isa_data_oe && isa_data_out != 8'h00) || (isa_data_oe && aen))
                i_bad = 1'b1;
        end else if (i_act) begin
            i_act = 1'b0;
            tests++;
            icnt++;
            if (iq.size() == 0) begin
                fails++;
                $display("FAIL isa_unexpected_%0d act seen=%b data=%h wait=%0d req none", icnt, i_seen, i_d, i_wt);
            end else begin
                e = iq.pop_front();
                if (e.seen !== i_seen || e.d !== i_d || e.wt != i_wt || i_bad) begin
                    fails++;
                    $display("FAIL isa_cycle_%0d act seen=%b data=%h wait=%0d bad=%b req seen=%b data=%h wait=%0d bad=0",
                             icnt, i_seen, i_d, i_wt, i_bad, e.seen, e.d, e.wt);
                end
            end
        end else if (isa_data_oe)
            stray++;
        if (cb_b_b1 | cb_cx1) begin
            if (!c_act) begin
                c_act = 1'b1;
                c_len = 0;
                c_oe = 0;
                c_wr = cb_cx1;
                c_a = cb_addr;
                c_d = cb_data_out;
            end
            c_len++;
            if (cb_data_oe)
                c_oe++;
        end else if (c_act) begin
            c_act = 1'b0;
            tests++;
            ccnt++;
            if (cq.size() == 0) begin
                fails++;
                $display("FAIL cb_unexpected_%0d act wr=%b addr=%h len=%0d req none", ccnt, c_wr, c_a, c_len);
            end else begin
                c = cq.pop_front();
                if (c.wr !== c_wr || c.a !== c_a || c.len != c_len || c.oe != c_oe || (c.wr && c.d !== c_d)) begin
                    fails++;
                    $display("FAIL cb_cycle_%0d act wr=%b addr=%h data=%h len=%0d oe=%0d req wr=%b addr=%h data=%h len=%0d oe=%0d",
                             ccnt, c_wr, c_a, c_d, c_len, c_oe, c.wr, c.a, c.d, c.len, c.oe);
                end
            end
        end
        if (done && !fin) begin
            tests += 2;
            if (iq.size() != 0 || cq.size() != 0 || sq.size() != 0) begin
                fails++;
                $display("FAIL drain act isa=%0d cb=%0d snap=%0d req 0 0 0", iq.size(), cq.size(), sq.size());
            end
            if (stray != 0) begin
                fails++;
                $display("FAIL passivity act stray_oe=%0d req 0", stray);
            end
            fin = 1'b1;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        snap("reset", RST_V);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        exp_cb(1'b0, 12'h003, 16'h0000, 3, 0);
        exp_isa(1'b1, 8'h5A, 5);
        isa_cyc(1'b1, 1'b0, 10'h106, 8'h00, 1'b0, 0);
        exp_isa(1'b1, 8'hA5, 0);
        isa_cyc(1'b1, 1'b0, 10'h107, 8'h00, 1'b0, 0);
        exp_isa(1'b0, 8'h00, 0);
        isa_cyc(1'b1, 1'b0, 10'h034, 8'h00, 1'b0, 0);
        exp_isa(1'b0, 8'h00, 0);
        isa_cyc(1'b1, 1'b0, 10'h106, 8'h00, 1'b1, 0);
        resp_en = 1'b0;
        exp_cb(1'b0, 12'h000, 16'h0000, 3, 0);
        exp_isa(1'b1, 8'hFF, 32);
        isa_cyc(1'b1, 1'b0, 10'h100, 8'h00, 1'b0, 0);
        resp_en = 1'b1;
        exp_isa(1'b1, 8'h01, 0);
        isa_cyc(1'b1, 1'b0, 10'h108, 8'h00, 1'b0, 0);
        exp_isa(1'b1, 8'h00, 0);
        isa_cyc(1'b1, 1'b0, 10'h108, 8'h00, 1'b0, 0);
        exp_isa(1'b0, 8'h00, 0);
        isa_cyc(1'b0, 1'b1, 10'h100, 8'h34, 1'b0, 0);
        exp_cb(1'b1, 12'h000, 16'h1234, 3, 3);
        exp_isa(1'b0, 8'h00, 5);
        isa_cyc(1'b0, 1'b1, 10'h101, 8'h12, 1'b0, 0);
        exp_cb(1'b0, 12'h001, 16'h0000, 3, 0);
        exp_isa(1'b0, 8'h00, 1);
        isa_cyc(1'b1, 1'b0, 10'h102, 8'h00, 1'b0, 2);
        exp_isa(1'b1, 8'h00, 0);
        isa_cyc(1'b1, 1'b0, 10'h103, 8'h00, 1'b0, 0);
        exp_isa(1'b1, 8'hA5, 0);
        isa_cyc(1'b1, 1'b1, 10'h107, 8'h00, 1'b0, 0);
        @(posedge clk);
        #1;
        zk4 = 1'b0;
        @(posedge clk);
        #1;
        snap("irq_1cyc", IDLE0_V);
        @(posedge clk);
        #1;
        snap("irq_2cyc", IDLEL_V);
        exp_isa(1'b1, {5'b0, LAM, 2'b00}, 0);
        isa_cyc(1'b1, 1'b0, 10'h108, 8'h00, 1'b0, 0);
        zk4 = 1'b1;
        repeat (4) @(posedge clk);
        resp_en = 1'b0;
        exp_cb(1'b0, 12'h000, 16'h0000, 3, 0);
        exp_isa(1'b0, 8'h00, 6);
        @(posedge clk);
        #1;
        addr = 10'h100;
        ior = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        snap("reset_mid", RST_V);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ior = 1'b1;
        resp_en = 1'b1;
        repeat (4) @(posedge clk);
        exp_isa(1'b1, 8'h00, 0);
        isa_cyc(1'b1, 1'b0, 10'h107, 8'h00, 1'b0, 0);
        done = 1'b1;
        for (int i = 0; i < 50 && !fin; i++) @(posedge clk);
        if (!fin) begin
            $display("FAIL final_drain act fin=%b req fin=1", fin);
            $fatal(1, "monitor did not finish");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
